// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, glyph patterns for
// the hex digits (both forms of 9), the blank pattern, and the scan-decoder
// state encoding.
package seg7_pkg;

    // Segment lines are packed a..g from bit 6 down to bit 0.
    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;
    localparam int SEG_W     = 7;

    // Glyph patterns, abcdefg, active-high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    // Some encoders draw 9 without the bottom bar.
    localparam logic [SEG_W-1:0] SEG_9_ALT = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Dwell tracking states for the scan decoder.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        CAPTURED = 2'd2
    } seg_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: maps a 7-bit abcdefg pattern to its hex
// nibble, flags whether the pattern is a legal glyph, and flags all-off.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_legal,
    output logic       o_blank
);

    // Pattern lookup; anything not listed is illegal and reads as nibble 0.
    always_comb begin
        o_nibble = 4'h0;
        o_legal  = 1'b0;
        o_blank  = 1'b0;
        case (i_seg)
            SEG_0:            begin o_nibble = 4'h0; o_legal = 1'b1; end
            SEG_1:            begin o_nibble = 4'h1; o_legal = 1'b1; end
            SEG_2:            begin o_nibble = 4'h2; o_legal = 1'b1; end
            SEG_3:            begin o_nibble = 4'h3; o_legal = 1'b1; end
            SEG_4:            begin o_nibble = 4'h4; o_legal = 1'b1; end
            SEG_5:            begin o_nibble = 4'h5; o_legal = 1'b1; end
            SEG_6:            begin o_nibble = 4'h6; o_legal = 1'b1; end
            SEG_7:            begin o_nibble = 4'h7; o_legal = 1'b1; end
            SEG_8:            begin o_nibble = 4'h8; o_legal = 1'b1; end
            SEG_9, SEG_9_ALT: begin o_nibble = 4'h9; o_legal = 1'b1; end
            SEG_A:            begin o_nibble = 4'hA; o_legal = 1'b1; end
            SEG_B:            begin o_nibble = 4'hB; o_legal = 1'b1; end
            SEG_C:            begin o_nibble = 4'hC; o_legal = 1'b1; end
            SEG_D:            begin o_nibble = 4'hD; o_legal = 1'b1; end
            SEG_E:            begin o_nibble = 4'hE; o_legal = 1'b1; end
            SEG_F:            begin o_nibble = 4'hF; o_legal = 1'b1; end
            SEG_BLANK:        begin o_blank  = 1'b1; end
            default:          begin o_legal  = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for the multiplexed seven-segment bus. Samples
// {an_in, seg_in}, waits for a dwell to stay unchanged for STABLE_CYCLES
// edges, then captures it once into the per-digit value/valid/blank
// registers, tracks which digits have been seen for frame_valid, and
// raises sticky error flags for bad anode or segment patterns.
// dbg_state exposes the dwell FSM state for observation.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic                    frame_valid,
    output logic                    err_pattern,
    output logic                    err_anode,
    output logic [1:0]              dbg_state
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int SQ_W  = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    seg_state_t            r_state;
    seg_state_t            w_state_nxt;
    logic [SQ_W-1:0]       r_s_q;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_DIGITS-1:0] r_mask;

    logic [SQ_W-1:0]       w_sample;
    logic                  w_change;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_an;
    logic [6:0]            w_seg;
    logic                  w_an_none;
    logic                  w_an_multi;
    logic                  w_an_onehot;
    logic                  w_cap_digit;
    logic [NUM_DIGITS-1:0] w_mask_merged;
    logic                  w_frame_done;
    logic [3:0]            w_nibble;
    logic                  w_legal;
    logic                  w_blank;

    assign w_sample = {an_in, seg_in};
    assign w_change = (w_sample != r_s_q);

    // The captured dwell is whatever sits in the sample register; on the
    // capture edge it is known to equal the live inputs.
    assign w_an  = r_s_q[SQ_W-1:7];
    assign w_seg = r_s_q[6:0];

    // One-hot test: nonzero with no second bit set.
    assign w_an_none   = (w_an == '0);
    assign w_an_multi  = ((w_an & (w_an - NUM_DIGITS'(1))) != '0);
    assign w_an_onehot = !w_an_none && !w_an_multi;

    assign w_cap_digit   = w_capture && w_an_onehot;
    assign w_mask_merged = r_mask | w_an;
    assign w_frame_done  = w_cap_digit && (w_mask_merged == '1);

    assign dbg_state = r_state;

    seg7_glyph_decode u_decode (
        .i_seg    (w_seg),
        .o_nibble (w_nibble),
        .o_legal  (w_legal),
        .o_blank  (w_blank)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: any input change restarts settling; a full stable run
    // in SETTLE produces a single capture and parks in CAPTURED.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (w_change) begin
            w_state_nxt = SETTLE;
        end else if (r_state == SETTLE && r_cnt == CNT_LAST) begin
            w_capture   = 1'b1;
            w_state_nxt = CAPTURED;
        end
    end

    // Sample register and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q <= '0;
            r_cnt <= '0;
        end else if (w_change) begin
            r_s_q <= w_sample;
            r_cnt <= '0;
        end else if (r_state == SETTLE && !w_capture) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Per-digit value, valid and blank registers, updated on a one-hot capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_out   <= '0;
            digit_valid <= '0;
            blank       <= '0;
        end else if (w_cap_digit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_an[i]) begin
                    if (w_legal) begin
                        value_out[4*i +: 4] <= w_nibble;
                        digit_valid[i]      <= 1'b1;
                        blank[i]            <= 1'b0;
                    end else if (w_blank) begin
                        digit_valid[i]      <= 1'b0;
                        blank[i]            <= 1'b1;
                    end else begin
                        digit_valid[i]      <= 1'b0;
                        blank[i]            <= 1'b0;
                    end
                end
            end
        end
    end

    // Frame mask and frame_valid pulse: pulse on the edge that completes
    // the set of digits, clearing the mask on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= w_frame_done;
            if (w_cap_digit) begin
                r_mask <= w_frame_done ? '0 : w_mask_merged;
            end
        end
    end

    // Sticky error flags; a new error on the clearing edge takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_anode   <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            if (w_capture && w_an_multi) begin
                err_anode <= 1'b1;
            end else if (clr_err) begin
                err_anode <= 1'b0;
            end
            if (w_cap_digit && !w_legal && !w_blank) begin
                err_pattern <= 1'b1;
            end else if (clr_err) begin
                err_pattern <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed dwells, a dwell-timestamp model of
// the display bus, a per-cycle compare process and literal checkpoints.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int S  = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [6:0]  seg_in  = '0;
  logic [3:0]  an_in   = '0;
  logic        clr_err = 1'b0;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_anode;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .clr_err     (clr_err),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_anode   (err_anode),
    .dbg_state   (dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int fv_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Glyph table indexed by hex value; 9 also accepts 1110011.
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Returns 0..15 for a legal glyph, 16 for all-off, -1 for anything else.
  function automatic int decode(input logic [6:0] s);
    if (s == 7'h73) return 9;
    for (int v = 0; v < 16; v++) if (glyph[v] == s) return v;
    if (s == 7'h00) return 16;
    return -1;
  endfunction

  logic [3:0]    m_val [ND];
  logic [ND-1:0] m_dv, m_bl, m_mask;
  logic          m_fv, m_ep, m_ea;
  logic [10:0]   m_last;
  longint        m_edge, m_change_edge;
  bit            m_pending;

  // A dwell is captured exactly S edges after the edge on which its value
  // first appeared, provided nothing changed in between.
  always @(posedge clk or negedge rst_n) begin : model
    logic [10:0] cur;
    int ones, idx, d;
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) m_val[i] = '0;
      m_dv = '0; m_bl = '0; m_mask = '0;
      m_fv = 0; m_ep = 0; m_ea = 0;
      m_last = '0; m_edge = 0; m_change_edge = 0; m_pending = 0;
    end else begin
      m_edge++;
      m_fv = 0;
      if (clr_err) begin m_ep = 0; m_ea = 0; end
      cur = {an_in, seg_in};
      if (cur !== m_last) begin
        m_last = cur; m_change_edge = m_edge; m_pending = 1;
      end else if (m_pending && (m_edge - m_change_edge) == S) begin
        m_pending = 0;
        ones = $countones(cur[10:7]);
        if (ones > 1) m_ea = 1;
        else if (ones == 1) begin
          idx = 0;
          for (int i = 0; i < ND; i++) if (cur[7+i]) idx = i;
          d = decode(cur[6:0]);
          if (d >= 0 && d < 16) begin
            m_val[idx] = 4'(d); m_dv[idx] = 1; m_bl[idx] = 0;
          end else if (d == 16) begin
            m_bl[idx] = 1; m_dv[idx] = 0;
          end else begin
            m_dv[idx] = 0; m_bl[idx] = 0; m_ep = 1;
          end
          m_mask[idx] = 1;
          if (&m_mask) begin m_fv = 1; m_mask = '0; end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [15:0] exp_v;
    for (int i = 0; i < ND; i++) exp_v[4*i +: 4] = m_val[i];
    check("value_out",   32'(value_out),   32'(exp_v));
    check("digit_valid", 32'(digit_valid), 32'(m_dv));
    check("blank",       32'(blank),       32'(m_bl));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("err_pattern", 32'(err_pattern), 32'(m_ep));
    check("err_anode",   32'(err_anode),   32'(m_ea));
    if (frame_valid) fv_seen++;
  end

  // ---------------- driver ----------------
  // Called at a falling edge: apply a dwell and hold it for n cycles.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in = a; seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  logic [6:0] churn [6] = '{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h7E};
  int fv0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("reset_value_out", 32'(value_out), 32'h0);
    check("reset_digit_valid", 32'(digit_valid), 32'h0);
    check("reset_blank", 32'(blank), 32'h0);

    // Latency: nothing after edge 15, nibble 3 after edge 16.
    an_in = 4'b0001; seg_in = 7'b1111001;
    repeat (S) @(negedge clk);
    check("t1_edge15_dv0", 32'(digit_valid[0]), 32'h0);
    @(negedge clk);
    check("t1_edge16_dv0", 32'(digit_valid[0]), 32'h1);
    check("t1_nibble0", 32'(value_out[3:0]), 32'h3);
    repeat (4) @(negedge clk);

    // Full scan 1, A, 9 (short form), F.
    fv0 = fv_seen;
    dwell(4'b0001, 7'b0110000, 20);
    dwell(4'b0010, 7'b1110111, 20);
    dwell(4'b0100, 7'b1110011, 20);
    dwell(4'b1000, 7'b1000111, 20);
    check("scan_value", 32'(value_out), 32'hF9A1);
    check("scan_fv_count", 32'(fv_seen - fv0), 32'h1);

    // Segments churn every 10 cycles: nothing captured.
    fv0 = fv_seen;
    for (int k = 0; k < 6; k++) dwell(4'b0001, churn[k], 10);
    check("churn_value", 32'(value_out), 32'hF9A1);
    check("churn_fv", 32'(fv_seen - fv0), 32'h0);

    // Display off: no update, no error.
    dwell(4'b0000, 7'h7F, 20);
    check("off_value", 32'(value_out), 32'hF9A1);
    check("off_err_anode", 32'(err_anode), 32'h0);

    // Two anodes: anode error, values held; then clear.
    dwell(4'b0110, 7'h7E, 20);
    check("anode_err", 32'(err_anode), 32'h1);
    check("anode_value", 32'(value_out), 32'hF9A1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    check("anode_cleared", 32'(err_anode), 32'h0);

    // clr_err on the capture edge: the error still lands.
    an_in = 4'b0011; seg_in = 7'h7E;
    repeat (S) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("err_wins_over_clr", 32'(err_anode), 32'h1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);

    // Illegal glyph on digit 2.
    dwell(4'b0100, 7'b1010101, 20);
    check("pat_err", 32'(err_pattern), 32'h1);
    check("pat_dv2", 32'(digit_valid[2]), 32'h0);
    check("pat_nibble2", 32'(value_out[11:8]), 32'h9);

    // Blank digit 1 held for 100 cycles.
    fv0 = fv_seen;
    dwell(4'b0010, 7'b0000000, 100);
    check("blank1", 32'(blank[1]), 32'h1);
    check("blank_dv1", 32'(digit_valid[1]), 32'h0);
    check("blank_nibble1", 32'(value_out[7:4]), 32'hA);
    check("blank_fv", 32'(fv_seen - fv0), 32'h0);

    // Reset mid-frame.
    dwell(4'b0001, 7'h5B, 20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_value_out", 32'(value_out), 32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_err_pattern", 32'(err_pattern), 32'h0);
    an_in = '0; seg_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Post-reset scan 2, 4, C, d: frame only after all four.
    fv0 = fv_seen;
    an_in = 4'b0001; seg_in = 7'h6D;
    repeat (S) @(negedge clk);
    check("rst_lat_edge15", 32'(digit_valid[0]), 32'h0);
    @(negedge clk);
    check("rst_lat_edge16", 32'(digit_valid[0]), 32'h1);
    repeat (3) @(negedge clk);
    dwell(4'b0010, 7'h33, 20);
    dwell(4'b0100, 7'h4E, 20);
    check("rst_no_early_frame", 32'(fv_seen - fv0), 32'h0);
    dwell(4'b1000, 7'h3D, 20);
    check("rst_frame", 32'(fv_seen - fv0), 32'h1);
    check("rst_scan_value", 32'(value_out), 32'hDC42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Segment-to-value decoder for the multiplexed seven-segment display bus: it samples the segment lines and digit-enable lines, waits for each dwell to settle, and rebuilds the hexadecimal value shown on every digit. It is the receive end of the display path. It sits beside the display output as a loopback monitor, so self-test logic can compare the value shown against the distance value commanded.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (≥1)
- STABLE_CYCLES, 16, consecutive unchanged clock cycles required before a dwell is accepted (≥2)

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seg_in  in  7  segment lines, active-high; bit 6 = a … bit 0 = g
- an_in  in  NUM_DIGITS  digit enables, active-high, one-hot expected; bit i = digit i
- clr_err  in  1  synchronous clear of sticky error flags
- value_out  out  4*NUM_DIGITS  decoded nibbles; nibble i = bits [4i+3:4i]
- digit_valid  out  NUM_DIGITS  digit i last captured a legal hex glyph
- blank  out  NUM_DIGITS  digit i last captured all-segments-off
- frame_valid  out  1  one-cycle pulse: every digit captured since the previous pulse
- err_pattern  out  1  sticky: an illegal glyph was captured
- err_anode  out  1  sticky: a stable dwell had more than one an_in bit set

## Operation
- seg_in and an_in are synchronous to clk. Sample register s_q holds {an, seg}.
- States:
  - IDLE: after reset.
  - SETTLE: counting stability.
  - CAPTURED: dwell consumed; waiting for the next change.
- Every edge:
  - If {an_in, seg_in} ≠ s_q: load s_q, cnt←0, go to SETTLE.
  - Else in SETTLE with cnt = STABLE_CYCLES−1: capture, go to CAPTURED.
  - Else in SETTLE: cnt++.
  - IDLE and CAPTURED hold until an input change.
- Capture action, by s_q.an:
  - All zero: no update, no error; display off.
  - More than one bit set: err_anode←1; no digit updated; mask unchanged.
  - One-hot, digit i, legal glyph: nibble i←decoded value, digit_valid[i]←1, blank[i]←0.
  - One-hot, digit i, seg = 0000000: blank[i]←1, digit_valid[i]←0, nibble i unchanged.
  - One-hot, digit i, other pattern: digit_valid[i]←0, blank[i]←0, nibble i unchanged, err_pattern←1.
- Legal glyphs (abcdefg):
  - 0 1111110; 1 0110000; 2 1101101; 3 1111001; 4 0110011; 5 1011011; 6 1011111; 7 1110000; 8 1111111.
  - 9 is either 1111011 or 1110011.
  - A 1110111; b 0011111; C 1001110; d 0111101; E 1001111; F 1000111.
- Frame mask:
  - Bit i sets on any one-hot capture of digit i (legal, blank or illegal).
  - When the mask becomes all ones, frame_valid pulses on that same edge and the mask clears.
  - Recapturing a digit before the others only overwrites that digit's outputs.
- clr_err clears both sticky flags. If an error and clr_err occur on the same edge, the error wins.

## Timing
- A new input value is registered at edge 0. Capture registers at edge STABLE_CYCLES. Outputs are visible after that edge, so latency = STABLE_CYCLES cycles.
- Any input change before capture restarts the count. No partial capture.
- Exactly one capture per dwell. Holding inputs indefinitely does not retrigger capture or frame_valid.
- cnt width = $clog2(STABLE_CYCLES).
- Reset values:
  - All outputs 0, including value_out, digit_valid, blank, frame_valid, err_pattern and err_anode.
  - s_q = 0, cnt = 0, mask = 0, state IDLE.
- Reset asserted mid-dwell or mid-frame clears everything immediately. The first dwell after release needs a full STABLE_CYCLES again, because s_q = 0 differs from any enabled input.

## Structure
- Package seg7_pkg: segment bit-order constants, SEG_0…SEG_F glyph constants (both 9 forms), SEG_BLANK, and the state enum {IDLE, SETTLE, CAPTURED}. The encoder side shares the glyph constants.
- Sub-module seg7_glyph_decode: combinational; 7-bit pattern → 4-bit nibble, legal, is_blank.
- Top level holds s_q, cnt, FSM, per-digit registers, frame mask and error flags.

## Test plan
- Hold an=0001, seg=1111001 for 16 cycles → nibble0=3, digit_valid[0]=1 exactly after edge 16. No update at edge 15.
- Scan digits 0–3 with glyphs 1, A, 9(1110011), F, 20 cycles each → value_out=16'hF9A1 and a single frame_valid pulse on the digit-3 capture edge.
- Change seg every 10 cycles with an fixed → no capture, outputs unchanged, frame_valid never pulses.
- Dwell an=0110 → err_anode=1, value_out unchanged. Assert clr_err → err_anode=0. Then dwell 1010101 on digit 2 → err_pattern=1, digit_valid[2]=0, nibble2 held.
- Dwell 0000000 on digit 1 → blank[1]=1, digit_valid[1]=0. Hold 100 cycles → no second capture.
- Assert rst_n low mid-frame (two digits captured) → all outputs 0 immediately. After release, a full 4-digit scan is needed before frame_valid.
